gray_conv_arbiter: RTL and testbench
====================================

# gray_conv_arbiter

Round-robin arbiter and sequencer that shares one binary-to-Gray converter among R requesters. Each requester presents an N-bit binary word with a valid/ready handshake. The block grants one requester per cycle, converts the word, and registers the result with its source ID on a single valid/ready output port. It sits between the producers (counters and pointer generators) and the downstream Gray-coded consumer.

## Interface
- N, 16: data width in bits, N ≥ 2.
- R, 4: number of requesters, R ≥ 2.
- IW, $clog2(R): ID width, derived and not overridable.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- req_valid  in  R  per-requester valid.
- req_bin  in  R*N  packed binary words; requester i occupies bits [i*N +: N].
- req_ready  out  R  per-requester ready; at most one bit high.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream ready.
- out_gray  out  N  Gray result.
- out_bin  out  N  original binary word, for checking.
- out_id  out  IW  index of the granted requester.

## Operation
- FSM with two states:
  - EMPTY: the output register holds no data.
  - FULL: out_valid=1.
- Accept condition: `can_accept = EMPTY | (FULL & out_ready)`.
- Round-robin pointer `ptr` (IW bits):
  - Grant goes to the first i with req_valid[i]=1, searching ptr, ptr+1, … with wrap mod R.
  - req_ready[grant]=can_accept & |req_valid. All other req_ready bits are 0.
- Transfer on requester g occurs when req_valid[g] & req_ready[g]. At the clock edge:
  - out_bin ← req_bin[g]
  - out_gray[N-1] ← bin[N-1]
  - out_gray[N-2:0] ← bin[N-1:1] ^ bin[N-2:0]
  - out_id ← g
  - ptr ← (g+1) mod R, which wraps R-1 to 0
  - state ← FULL
- Drain without a new transfer (FULL & out_ready & no req_valid): state ← EMPTY. out_gray, out_bin and out_id keep their last values.
- Simultaneous drain and transfer: the register reloads in the same edge and stays FULL. Full throughput is one word per cycle.
- If no requester is valid, ptr does not move.
- Requester rules:
  - A requester holds req_valid and req_bin stable until it sees ready.
  - The arbiter never drops or duplicates a word.
- While FULL & !out_ready, out_gray, out_bin and out_id are stable.

## Timing
- Reset (rst_n low, asynchronous):
  - state=EMPTY, out_valid=0, out_gray=0, out_bin=0, out_id=0, ptr=0.
  - req_ready is forced to all-zero while rst_n=0.
- Latency: a word accepted at edge k is on the output with out_valid=1 from edge k until it is drained.
- req_ready is combinational from req_valid, out_ready and state. It must not depend on req_bin.
- out_* are registered outputs, with no combinational path from inputs.
- Reset asserted mid-transfer: the pending output is discarded and the block returns to the reset values. The first grant after release starts from requester 0.
- R not a power of two: ptr wraps explicitly at R-1. IDs ≥ R are never produced.

## Structure
- Package `gray_conv_pkg`:
  - state enum {EMPTY, FULL}
  - default N and R localparams
  - function `bin2gray(N-bit)`, shared with the bench's scoreboard
- Sub-module `rr_grant` (parameter R):
  - inputs: req vector, ptr
  - outputs: one-hot grant, encoded grant index, any_req
  - purely combinational, reusable by other arbiters
- Top level holds the FSM, pointer register and output register.

## Test plan
All scenarios use N=16, R=4.

- Reset values: hold rst_n=0 with random inputs → out_valid=0, out_gray=0x0000, out_id=0, req_ready=4'b0000.
- Single word: req_valid=4'b0100, req_bin[2]=0x1234, out_ready=1 → next cycle out_valid=1, out_gray=0x1B2E, out_bin=0x1234, out_id=2. Then ptr=3.
- Edge words, each on its own requester: input 0xFFFF → out_gray 0x8000; input 0x8000 → 0xC000; input 0x0005 → 0x0007; input 0x0000 → 0x0000.
- Fairness: all four valid continuously, out_ready=1 → out_id sequence 0,1,2,3,0,1 with out_valid high every cycle, no gaps.
- Backpressure: out_ready=0 for 5 cycles while FULL → out_* stable and req_ready=0000. Raise out_ready with req_valid=0001 → drain and reload in the same cycle, state stays FULL.
- Reset mid-stream: assert rst_n low asynchronously while FULL with ptr=2 → out_valid drops immediately. After release with all valid, the first out_id is 0.

Source files
------------

// File: rtl/gray_conv_arbiter_pkg.sv
// gray_conv_pkg: shared types, default sizes and the binary-to-Gray helper
// for the gray_conv_arbiter block.
//   state_t   : output-register occupancy (EMPTY / FULL)
//   N_DEF     : default data width
//   R_DEF     : default requester count
//   bin2gray  : Gray encoding of a zero-extended word of up to GRAY_MAX_W bits
package gray_conv_pkg;

  localparam int N_DEF      = 16;
  localparam int R_DEF      = 4;
  localparam int GRAY_MAX_W = 64;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Zero-extension leaves the Gray code of the low bits unchanged, so callers
  // with narrower words widen the argument and truncate the result.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ {1'b0, bin[GRAY_MAX_W-1:1]};
  endfunction

endpackage

// File: rtl/gray_conv_arbiter_if.sv
// gray_conv_arbiter_if: request and result handshake bundle.
//   req_valid / req_bin / req_ready : R requester channels, word i at [i*N +: N]
//   out_valid / out_ready           : result handshake
//   out_gray / out_bin / out_id     : Gray word, original word, source index
// master: producers plus downstream consumer side; slave: the arbiter.
interface gray_conv_arbiter_if
  import gray_conv_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int R = R_DEF
);

  localparam int IW = $clog2(R);

  logic [R-1:0]   req_valid;
  logic [R*N-1:0] req_bin;
  logic [R-1:0]   req_ready;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_gray;
  logic [N-1:0]   out_bin;
  logic [IW-1:0]  out_id;

  modport master (
    output req_valid, req_bin, out_ready,
    input  req_ready, out_valid, out_gray, out_bin, out_id
  );

  modport slave (
    input  req_valid, req_bin, out_ready,
    output req_ready, out_valid, out_gray, out_bin, out_id
  );

endinterface

// File: rtl/gray_conv_arbiter_rr_grant.sv
// rr_grant: combinational round-robin grant search.
//   req       in  R   request vector
//   ptr       in  IW  first index to consider (must be < R)
//   grant     out R   one-hot grant, zero when nothing requests
//   grant_idx out IW  encoded grant index, zero when nothing requests
//   any_req   out 1   OR of all requests
module rr_grant #(
  parameter int R = 4,
  localparam int IW = $clog2(R)
) (
  input  logic [R-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [R-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);

  logic [IW:0]   raw_sum_s;
  logic [IW:0]   wrap_sum_s;
  logic [IW-1:0] cand_s;
  logic          found_s;

  // Scan ptr, ptr+1, ... with an explicit wrap at R so non-power-of-two R
  // never produces an index >= R.
  always_comb begin
    grant      = '0;
    grant_idx  = '0;
    found_s    = 1'b0;
    raw_sum_s  = '0;
    wrap_sum_s = '0;
    cand_s     = '0;
    for (int k = 0; k < R; k++) begin
      raw_sum_s  = {1'b0, ptr} + (IW+1)'(k);
      wrap_sum_s = (raw_sum_s >= (IW+1)'(R)) ? (raw_sum_s - (IW+1)'(R)) : raw_sum_s;
      cand_s     = wrap_sum_s[IW-1:0];
      if (!found_s && req[cand_s]) begin
        found_s   = 1'b1;
        grant_idx = cand_s;
      end else begin
        found_s   = found_s;
      end
    end
    grant[grant_idx] = found_s;
  end

  // Any pending request at all.
  always_comb begin
    any_req = |req;
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin sharing of one binary-to-Gray converter
// among R requesters, with a single registered valid/ready result port.
//   clk   in  rising-edge clock
//   rst_n in  asynchronous active-low reset
//   bus   slave modport of gray_conv_arbiter_if (requests in, result out)
// The output register is reloaded on every transfer; a drain and a new
// transfer in the same cycle keep the register FULL for full throughput.
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int R = R_DEF,
  localparam int IW = $clog2(R)
) (
  input logic                clk,
  input logic                rst_n,
  gray_conv_arbiter_if.slave bus
);

  localparam logic [IW-1:0] ID_LAST = IW'(R - 1);
  localparam logic [IW-1:0] ID_ONE  = IW'(1);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [IW-1:0] ptr_r;
  logic [IW-1:0] ptr_nxt_s;
  logic [N-1:0]  gray_r;
  logic [N-1:0]  bin_r;
  logic [IW-1:0] id_r;

  logic [R-1:0]  grant_s;
  logic [IW-1:0] grant_idx_s;
  logic          any_req_s;
  logic          can_accept_s;
  logic          transfer_s;
  logic [N-1:0]  sel_bin_s;
  logic [N-1:0]  sel_gray_s;

  rr_grant #(.R(R)) u_rr_grant (
    .req       (bus.req_valid),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any_req   (any_req_s)
  );

  // Room for a new word: register empty, or emptying this cycle.
  always_comb begin
    can_accept_s = 1'b0;
    case (state_r)
      EMPTY:   can_accept_s = 1'b1;
      FULL:    can_accept_s = bus.out_ready;
      default: can_accept_s = 1'b0;
    endcase
  end

  assign transfer_s = can_accept_s & any_req_s;

  // Ready goes only to the granted requester; held low throughout reset.
  always_comb begin
    if (rst_n) begin
      bus.req_ready = grant_s & {R{can_accept_s}};
    end else begin
      bus.req_ready = '0;
    end
  end

  // Next state of the output register occupancy.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (transfer_s) begin
          state_nxt_s = FULL;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      FULL: begin
        if (transfer_s) begin
          state_nxt_s = FULL;
        end else if (bus.out_ready) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // Pointer moves past the granted requester; idle cycles leave it alone.
  always_comb begin
    if (transfer_s) begin
      if (grant_idx_s == ID_LAST) begin
        ptr_nxt_s = '0;
      end else begin
        ptr_nxt_s = grant_idx_s + ID_ONE;
      end
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Grant is one-hot, so an AND-OR mux selects the granted word.
  always_comb begin
    sel_bin_s = '0;
    for (int i = 0; i < R; i++) begin
      sel_bin_s = sel_bin_s | (bus.req_bin[i*N +: N] & {N{grant_s[i]}});
    end
  end

  assign sel_gray_s = N'(bin2gray(GRAY_MAX_W'(sel_bin_s)));

  // State, pointer and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
      ptr_r   <= '0;
      gray_r  <= '0;
      bin_r   <= '0;
      id_r    <= '0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      if (transfer_s) begin
        gray_r <= sel_gray_s;
        bin_r  <= sel_bin_s;
        id_r   <= grant_idx_s;
      end
    end
  end

  assign bus.out_valid = (state_r == FULL);
  assign bus.out_gray  = gray_r;
  assign bus.out_bin   = bin_r;
  assign bus.out_id    = id_r;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb_gray_conv_arbiter: directed scoreboard bench for gray_conv_arbiter
// (N=16, R=4). Stimulus loads per-requester word queues and pushes the
// hand-computed result into the scoreboard; a negedge monitor pops and
// compares every result the DUT hands downstream.
module tb_gray_conv_arbiter;

  localparam int N = 16;
  localparam int R = 4;

  typedef struct packed {
    logic [15:0] gray;
    logic [15:0] bin;
    logic [1:0]  id;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [15:0] src_q [R][$];

  always #5 clk = ~clk;

  gray_conv_arbiter_if #(.N(N), .R(R)) bif ();

  gray_conv_arbiter #(.N(N), .R(R)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input logic [15:0] b, input logic [15:0] g);
    exp_t e;
    e.gray = g;
    e.bin  = b;
    e.id   = 2'(id);
    src_q[id].push_back(b);
    sb_q.push_back(e);
  endtask

  task automatic drive();
    logic [R-1:0]   v;
    logic [R*N-1:0] d;
    v = '0;
    d = '0;
    for (int i = 0; i < R; i++) begin
      if (src_q[i].size() > 0) begin
        v[i]         = 1'b1;
        d[i*N +: N]  = src_q[i][0];
      end
    end
    bif.req_valid = v;
    bif.req_bin   = d;
  endtask

  // One clock: note which requesters handshake, cross the edge, retire them.
  task automatic step();
    logic [R-1:0] fire;
    #2;
    fire = bif.req_valid & bif.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < R; i++) begin
      if (fire[i]) void'(src_q[i].pop_front());
    end
    drive();
  endtask

  function automatic logic busy();
    logic b;
    b = (sb_q.size() > 0);
    for (int i = 0; i < R; i++) begin
      if (src_q[i].size() > 0) b = 1'b1;
    end
    return b;
  endfunction

  task automatic run_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    chk(name, 32'(busy()), 32'd0);
  endtask

  task automatic clear_all();
    sb_q.delete();
    for (int i = 0; i < R; i++) src_q[i].delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_all();
    bif.req_valid = '0;
    bif.req_bin   = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive();
  endtask

  // Scoreboard monitor: every downstream handshake must match the next expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bif.out_valid === 1'b1 && bif.out_ready === 1'b1) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got id=%0d gray=%h bin=%h with nothing expected",
                 bif.out_id, bif.out_gray, bif.out_bin);
      end else begin
        mon_e = sb_q.pop_front();
        if (bif.out_gray !== mon_e.gray || bif.out_bin !== mon_e.bin || bif.out_id !== mon_e.id) begin
          bad++;
          $display("FAIL result: got id=%0d gray=%h bin=%h expected id=%0d gray=%h bin=%h",
                   bif.out_id, bif.out_gray, bif.out_bin, mon_e.id, mon_e.gray, mon_e.bin);
        end
      end
    end
  end

  initial begin
    // Reset with random inputs
    rst_n         = 1'b0;
    bif.req_valid = 4'($urandom);
    bif.req_bin   = {$urandom, $urandom};
    bif.out_ready = 1'($urandom);
    repeat (2) @(posedge clk);
    #1;
    bif.req_valid = 4'($urandom);
    bif.out_ready = 1'($urandom);
    #1;
    chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("rst_out_gray",  32'(bif.out_gray),  32'h0000);
    chk("rst_out_bin",   32'(bif.out_bin),   32'h0000);
    chk("rst_out_id",    32'(bif.out_id),    32'd0);
    chk("rst_req_ready", 32'(bif.req_ready), 32'h0);
    do_reset();
    bif.out_ready = 1'b1;

    // Single word on requester 2
    push(2, 16'h1234, 16'h1B2E);
    drive();
    #1;
    chk("single_req_ready", 32'(bif.req_ready), 32'b0100);
    step();
    chk("single_valid", 32'(bif.out_valid), 32'd1);
    chk("single_gray",  32'(bif.out_gray),  32'h1B2E);
    chk("single_bin",   32'(bif.out_bin),   32'h1234);
    chk("single_id",    32'(bif.out_id),    32'd2);
    run_idle("single_drain", 20);

    // Edge words; pointer now 3, so requester 3 is served before 0
    push(3, 16'hFFFF, 16'h8000);
    push(0, 16'h8000, 16'hC000);
    drive();
    #1;
    chk("ptr3_req_ready", 32'(bif.req_ready), 32'b1000);
    run_idle("edge_a_drain", 20);
    push(1, 16'h0005, 16'h0007);
    push(2, 16'h0000, 16'h0000);
    drive();
    #1;
    chk("ptr1_req_ready", 32'(bif.req_ready), 32'b0010);
    run_idle("edge_b_drain", 20);

    // Fairness: all four valid continuously, no gaps in out_valid
    do_reset();
    bif.out_ready = 1'b1;
    push(0, 16'h0001, 16'h0001);
    push(1, 16'h0002, 16'h0003);
    push(2, 16'h0003, 16'h0002);
    push(3, 16'h0004, 16'h0006);
    push(0, 16'h0006, 16'h0005);
    push(1, 16'h0007, 16'h0004);
    push(2, 16'h0008, 16'h000C);
    push(3, 16'h000F, 16'h0008);
    drive();
    for (int k = 0; k < 8; k++) begin
      step();
      chk("fair_no_gap", 32'(bif.out_valid), 32'd1);
    end
    run_idle("fair_drain", 20);

    // Backpressure: hold while FULL, then drain and reload in one edge
    do_reset();
    bif.out_ready = 1'b0;
    push(1, 16'h00F0, 16'h0088);
    drive();
    step();
    push(0, 16'h0100, 16'h0180);
    drive();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_req_ready", 32'(bif.req_ready), 32'h0);
      chk("bp_valid",     32'(bif.out_valid), 32'd1);
      chk("bp_gray",      32'(bif.out_gray),  32'h0088);
      chk("bp_bin",       32'(bif.out_bin),   32'h00F0);
      chk("bp_id",        32'(bif.out_id),    32'd1);
      step();
    end
    bif.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bif.req_ready), 32'b0001);
    step();
    chk("bp_stays_full", 32'(bif.out_valid), 32'd1);
    chk("bp_reload_id",  32'(bif.out_id),    32'd0);
    chk("bp_reload_gray", 32'(bif.out_gray), 32'h0180);
    run_idle("bp_drain", 20);

    // Reset mid-stream while FULL with ptr=2
    do_reset();
    bif.out_ready = 1'b0;
    push(1, 16'h0010, 16'h0018);
    drive();
    step();
    chk("mid_full", 32'(bif.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_valid_drop", 32'(bif.out_valid), 32'd0);
    chk("mid_ready_zero", 32'(bif.req_ready), 32'h0);
    chk("mid_gray_zero",  32'(bif.out_gray),  32'h0000);
    clear_all();
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bif.out_ready = 1'b1;
    push(0, 16'h0020, 16'h0030);
    push(1, 16'h0040, 16'h0060);
    push(2, 16'h0080, 16'h00C0);
    push(3, 16'h00FF, 16'h0080);
    drive();
    step();
    chk("mid_first_id", 32'(bif.out_id), 32'd0);
    run_idle("mid_drain", 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
